// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Keeps the fetch PC, issues word reads to instruction memory under a credit limit,
// buffers returned words in order and hands {pc, instr} to the decoder over valid/ready.
// A redirect flushes buffered words and discards responses still in flight.
// Optional feature macro: FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed,
`endif
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  cnt_t        outstanding_q, outstanding_d;  // accepted requests whose response is pending
  cnt_t        discard_q, discard_d;          // pending responses that belong to a flushed path

  // Instruction queue: {pc, instr} in program order.
  logic [31:0] q_pc_q    [DEPTH];
  logic [31:0] q_instr_q [DEPTH];
  ptr_t        q_wr_q, q_rd_q;
  cnt_t        q_cnt_q;

  // PC FIFO: address of every live outstanding request, matched to responses in order.
  logic [31:0] pf_pc_q [DEPTH];
  ptr_t        pf_wr_q, pf_rd_q;

  logic credit_ok, req_fire, rsp_take, push, pop;

  // Low address bits of the redirect target are forced to zero.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Handshake qualifiers and decoder-facing outputs.
  always_comb begin
    // Responses with nothing outstanding (e.g. in flight across a reset) are ignored.
    rsp_take       = imem_rsp_valid && (outstanding_q != '0);
    credit_ok      = (sum_t'(outstanding_q) + sum_t'(q_cnt_q)) < sum_t'(DEPTH);
    imem_req_valid = (state_q == StRun) && !redirect_valid && credit_ok;
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    push           = rsp_take && (state_q == StRun) && !redirect_valid;
    out_valid      = (q_cnt_q != '0);
    pop            = out_valid && out_ready && !redirect_valid;
    out_instr      = out_valid ? q_instr_q[q_rd_q] : '0;
    out_pc         = out_valid ? q_pc_q[q_rd_q] : '0;
  end

  // Next state, fetch PC and in-flight bookkeeping; redirect overrides everything.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(rsp_take);
    discard_d     = discard_q;

    unique case (state_q)
      StBoot: state_d = StRun;
      StRun:  state_d = StRun;
      StFlush: begin
        if (rsp_take) begin
          discard_d = discard_q - cnt_t'(1);
        end
        if (discard_d == '0) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      discard_d  = outstanding_q - cnt_t'(rsp_take);
      state_d    = (outstanding_d != '0) ? StFlush : StRun;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Instruction queue and PC FIFO storage; a redirect empties both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
        pf_pc_q[i]   <= '0;
      end
      q_wr_q  <= '0;
      q_rd_q  <= '0;
      q_cnt_q <= '0;
      pf_wr_q <= '0;
      pf_rd_q <= '0;
    end else if (redirect_valid) begin
      q_wr_q  <= '0;
      q_rd_q  <= '0;
      q_cnt_q <= '0;
      pf_wr_q <= '0;
      pf_rd_q <= '0;
    end else begin
      if (req_fire) begin
        pf_pc_q[pf_wr_q] <= fetch_pc_q;
        pf_wr_q          <= pf_wr_q + ptr_t'(1);
      end
      if (push) begin
        q_pc_q[q_wr_q]    <= pf_pc_q[pf_rd_q];
        q_instr_q[q_wr_q] <= imem_rsp_data;
        q_wr_q            <= q_wr_q + ptr_t'(1);
        pf_rd_q           <= pf_rd_q + ptr_t'(1);
      end
      if (pop) begin
        q_rd_q <= q_rd_q + ptr_t'(1);
      end
      q_cnt_q <= q_cnt_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] flush_inc;

  // Words lost to a redirect: buffered entries plus every dropped response.
  always_comb begin
    flush_inc = '0;
    if (redirect_valid) begin
      flush_inc = 32'(q_cnt_q);
    end
    if (rsp_take && (redirect_valid || (state_q == StFlush))) begin
      flush_inc = flush_inc + 32'd1;
    end
  end

  // Performance counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_flushed <= perf_flushed + flush_inc;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, hand-written redirect sequences and a randomized run
// against an in-order memory model and a stream-level reference of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
`ifdef FETCH_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed),
`endif
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: accepted requests return in order, no earlier than their due cycle.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t pend[$];
  int    lat_lo  = 1;
  int    lat_hi  = 1;
  int    rsp_pct = 100;

  // Reference model of the delivered stream.
  logic [31:0] exp_req_addr, exp_out_pc;
  int          stale, buffered;
  bit          boot;
  int          m_fetched, m_flushed;

  typedef struct {
    bit          rst;
    bit          ordy;
    bit          rrdy;
    bit          rv;
    logic [31:0] addr;
    bit          ov;
    logic [31:0] pc;
  } vec_t;
  localparam int NV = 31;
  vec_t tbl[NV];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  function automatic vec_t v(input bit r, input bit o, input bit q, input bit rv,
                             input logic [31:0] a, input bit ov, input logic [31:0] pc);
    vec_t t;
    t.rst = r; t.ordy = o; t.rrdy = q; t.rv = rv; t.addr = a; t.ov = ov; t.pc = pc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_flushed", perf_flushed, 32'd0);
`endif
    pend.delete();
    exp_req_addr = RST_PC;
    exp_out_pc   = RST_PC;
    stale        = 0;
    buffered     = 0;
    boot         = 1'b1;
    m_fetched    = 0;
    m_flushed    = 0;
    rst_n        = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit ordy, input bit rrdy, input bit redir, input logic [31:0] rpc,
                      output bit s_rv, output logic [31:0] s_addr,
                      output bit s_ov, output logic [31:0] s_pc);
    bit rsp, exp_rv, had_buf;
    out_ready      = ordy;
    imem_req_ready = rrdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    rsp = 1'b0;
    if (pend.size() > 0) begin
      if (pend[0].due <= cyc && int'($urandom_range(99)) < rsp_pct) rsp = 1'b1;
    end
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom();
    #1;
    s_rv   = imem_req_valid;
    s_addr = imem_req_addr;
    s_ov   = out_valid;
    s_pc   = out_pc;

    exp_rv = !boot && !redir && (stale == 0) && (pend.size() + buffered < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("req_addr", imem_req_addr, exp_req_addr);
    chk("out_valid", 32'(out_valid), 32'(buffered > 0));
    if (buffered > 0) begin
      chk("out_pc", out_pc, exp_out_pc);
      chk("out_instr", out_instr, mem_word(exp_out_pc));
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'(m_fetched));
    chk("perf_flushed", perf_flushed, 32'(m_flushed));
`endif

    had_buf = (buffered > 0);
    if (redir) begin
      m_flushed    += buffered + (rsp ? 1 : 0);
      stale         = pend.size() - (rsp ? 1 : 0);
      buffered      = 0;
      exp_req_addr  = {rpc[31:2], 2'b00};
      exp_out_pc    = exp_req_addr;
    end else begin
      if (rsp && stale > 0) begin
        stale--;
        m_flushed++;
      end else if (rsp) begin
        buffered++;
      end
      if (had_buf && ordy) begin
        buffered--;
        exp_out_pc += 32'd4;
        m_fetched++;
      end
      if (exp_rv && rrdy) exp_req_addr += 32'd4;
    end
    if (imem_req_valid && rrdy) begin
      pend.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
    end
    if (rsp) void'(pend.pop_front());
    boot = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rv, ov, found;
    logic [31:0] ad, pc;

    // Steady stream, 1-cycle memory, decoder always ready.
    tbl[0]  = v(1, 1, 1, 0, 32'h100, 0, 0);
    tbl[1]  = v(0, 1, 1, 1, 32'h100, 0, 0);
    tbl[2]  = v(0, 1, 1, 1, 32'h104, 0, 0);
    tbl[3]  = v(0, 1, 1, 0, 32'h108, 1, 32'h100);
    tbl[4]  = v(0, 1, 1, 1, 32'h108, 1, 32'h104);
    tbl[5]  = v(0, 1, 1, 1, 32'h10C, 0, 0);
    tbl[6]  = v(0, 1, 1, 0, 32'h110, 1, 32'h108);
    tbl[7]  = v(0, 1, 1, 1, 32'h110, 1, 32'h10C);
    // Decoder stalled 10 cycles: only DEPTH requests go out, then release.
    tbl[8]  = v(1, 0, 1, 0, 32'h100, 0, 0);
    tbl[9]  = v(0, 0, 1, 1, 32'h100, 0, 0);
    tbl[10] = v(0, 0, 1, 1, 32'h104, 0, 0);
    for (int i = 11; i < 18; i++) tbl[i] = v(0, 0, 1, 0, 32'h108, 1, 32'h100);
    tbl[18] = v(0, 1, 1, 0, 32'h108, 1, 32'h100);
    tbl[19] = v(0, 1, 1, 1, 32'h108, 1, 32'h104);
    tbl[20] = v(0, 1, 1, 1, 32'h10C, 0, 0);
    tbl[21] = v(0, 1, 1, 0, 32'h110, 1, 32'h108);
    // Memory stalled 5 cycles: address held, nothing delivered.
    tbl[22] = v(1, 1, 0, 0, 32'h100, 0, 0);
    for (int i = 23; i < 28; i++) tbl[i] = v(0, 1, 0, 1, 32'h100, 0, 0);
    tbl[28] = v(0, 1, 1, 1, 32'h100, 0, 0);
    tbl[29] = v(0, 1, 1, 1, 32'h104, 0, 0);
    tbl[30] = v(0, 1, 1, 0, 32'h108, 1, 32'h100);

    lat_lo = 1; lat_hi = 1; rsp_pct = 100;
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].ordy, tbl[i].rrdy, 1'b0, '0, rv, ad, ov, pc);
      chk($sformatf("tbl%0d_req_valid", i), 32'(rv), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_req_addr", i), ad, tbl[i].addr);
      chk($sformatf("tbl%0d_out_valid", i), 32'(ov), 32'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("tbl%0d_out_pc", i), pc, tbl[i].pc);
    end

    // Redirect with two requests outstanding; both stale responses must be dropped.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    repeat (3) step(1'b1, 1'b1, 1'b0, '0, rv, ad, ov, pc);
    step(1'b1, 1'b1, 1'b1, 32'h2002, rv, ad, ov, pc);
    step(1'b1, 1'b1, 1'b0, '0, rv, ad, ov, pc);
    chk("redir_addr", ad, 32'h2000);
    chk("redir_flush_rv0", 32'(rv), 32'd0);
    step(1'b1, 1'b1, 1'b0, '0, rv, ad, ov, pc);
    chk("redir_flush_rv1", 32'(rv), 32'd0);
    step(1'b1, 1'b1, 1'b0, '0, rv, ad, ov, pc);
    chk("redir_resume_rv", 32'(rv), 32'd1);
    chk("redir_resume_addr", ad, 32'h2000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, rv, ad, ov, pc);
      if (ov) begin
        found = 1'b1;
        chk("redir_first_pc", pc, 32'h2000);
      end
    end
    if (!found) chk("redir_first_seen", 32'd0, 32'd1);

    // Redirect in the same cycle as a response and a would-be pop.
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (3) step(1'b1, 1'b1, 1'b0, '0, rv, ad, ov, pc);
    step(1'b1, 1'b1, 1'b1, 32'h3000, rv, ad, ov, pc);
    chk("same_cyc_ov_before", 32'(ov), 32'd1);
    step(1'b1, 1'b1, 1'b0, '0, rv, ad, ov, pc);
    chk("same_cyc_ov_after", 32'(ov), 32'd0);
    chk("same_cyc_rv", 32'(rv), 32'd1);
    chk("same_cyc_addr", ad, 32'h3000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, '0, rv, ad, ov, pc);
      if (ov) begin
        found = 1'b1;
        chk("same_cyc_first_pc", pc, 32'h3000);
      end
    end
    if (!found) chk("same_cyc_first_seen", 32'd0, 32'd1);

`ifdef FETCH_PERF_EN
    // Five handshakes, then a full queue of two words flushed.
    do_reset();
    for (int i = 0; i < 40 && m_fetched < 5; i++) step(1'b1, 1'b1, 1'b0, '0, rv, ad, ov, pc);
    repeat (8) step(1'b0, 1'b1, 1'b0, '0, rv, ad, ov, pc);
    step(1'b0, 1'b1, 1'b1, 32'h4000, rv, ad, ov, pc);
    step(1'b0, 1'b1, 1'b0, '0, rv, ad, ov, pc);
    chk("perf6_fetched", perf_fetched, 32'd5);
    chk("perf6_flushed", perf_flushed, 32'd2);
`endif

    // Randomized traffic against the model.
    do_reset();
    lat_lo = 1; lat_hi = 4; rsp_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(3) != 0), ($urandom_range(2) != 0), ($urandom_range(24) == 0),
           $urandom(), rv, ad, ov, pc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
